// File: rtl/ptw_line_fetch.sv
// rtl/ptw_line_fetch.sv - walker line request to eight 64-bit bus read beats, assembled into a 512-bit line
// Optional one-entry line buffer with flush enabled by defining LINE_FETCH_HIT_EN.
module ptw_line_fetch #(
  parameter int MCN_W  = 58,
  parameter int ADDR_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_req_i_valid,
  output logic              mem_req_i_ready,
  input  logic [MCN_W-1:0]  mem_req_i_bits_mcn,
  output logic              mem_resp_o_valid,
  input  logic              mem_resp_o_ready,
  output logic [511:0]      mem_resp_o_bits_data,
  output logic              bus_req_o_valid,
  input  logic              bus_req_o_ready,
  output logic [ADDR_W-1:0] bus_req_o_bits_addr,
  input  logic              bus_resp_i_valid,
  output logic              bus_resp_i_ready,
  input  logic [63:0]       bus_resp_i_bits_data,
  input  logic              flush_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [MCN_W-1:0]   mcn_q, mcn_d;
  logic [3:0]         req_cnt_q, req_cnt_d;
  logic [3:0]         rsp_cnt_q, rsp_cnt_d;
  logic [511:0]       line_q, line_d;

  logic               req_hit;
  logic [511:0]       hit_line;
  logic               beat_req_fire;
  logic               beat_rsp_fire;
  logic               line_done;

  // Handshake-facing controls decode only from registered state and counters.
  assign mem_req_i_ready      = (state_q == S_IDLE);
  assign bus_req_o_valid      = (state_q == S_BUSY) && (req_cnt_q < 4'd8);
  assign bus_resp_i_ready     = (state_q == S_BUSY);
  assign mem_resp_o_valid     = (state_q == S_RESP);
  assign mem_resp_o_bits_data = line_q;
  assign bus_req_o_bits_addr  = ADDR_W'({mcn_q, req_cnt_q[2:0], 3'b000});

  assign beat_req_fire = bus_req_o_valid && bus_req_o_ready;
  assign beat_rsp_fire = bus_resp_i_ready && bus_resp_i_valid && (rsp_cnt_q < 4'd8);
  assign line_done     = beat_rsp_fire && (rsp_cnt_q == 4'd7);

`ifdef LINE_FETCH_HIT_EN
  logic               buf_vld_q, buf_vld_d;
  logic [MCN_W-1:0]   buf_tag_q, buf_tag_d;
  logic [511:0]       buf_data_q, buf_data_d;
  logic               flush_seen_q, flush_seen_d;

  // A flush in the same cycle as a matching request forces a bus fetch.
  assign req_hit  = buf_vld_q && !flush_i && (buf_tag_q == mem_req_i_bits_mcn);
  assign hit_line = buf_data_q;

  always_comb begin
    buf_vld_d    = buf_vld_q;
    buf_tag_d    = buf_tag_q;
    buf_data_d   = buf_data_q;
    flush_seen_d = flush_seen_q;
    if ((state_q == S_IDLE) && mem_req_i_valid && !req_hit) begin
      flush_seen_d = 1'b0;
    end
    if ((state_q == S_BUSY) && flush_i) begin
      flush_seen_d = 1'b1;
    end
    if (flush_i) begin
      buf_vld_d = 1'b0;
    end else if (line_done && !flush_seen_q) begin
      buf_vld_d  = 1'b1;
      buf_tag_d  = mcn_q;
      buf_data_d = line_d;
    end
  end
`else
  logic unused_flush;

  assign req_hit      = 1'b0;
  assign hit_line     = '0;
  assign unused_flush = flush_i;
`endif

  always_comb begin
    state_d   = state_q;
    mcn_d     = mcn_q;
    req_cnt_d = req_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    line_d    = line_q;
    case (state_q)
      S_IDLE: begin
        if (mem_req_i_valid) begin
          mcn_d     = mem_req_i_bits_mcn;
          req_cnt_d = 4'd0;
          rsp_cnt_d = 4'd0;
          if (req_hit) begin
            line_d  = hit_line;
            state_d = S_RESP;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (beat_req_fire) begin
          req_cnt_d = req_cnt_q + 4'd1;
        end
        if (beat_rsp_fire) begin
          line_d[{rsp_cnt_q[2:0], 6'b000000} +: 64] = bus_resp_i_bits_data;
          rsp_cnt_d = rsp_cnt_q + 4'd1;
        end
        if (line_done) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (mem_resp_o_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mcn_q     <= '0;
      req_cnt_q <= 4'd0;
      rsp_cnt_q <= 4'd0;
      line_q    <= '0;
`ifdef LINE_FETCH_HIT_EN
      buf_vld_q    <= 1'b0;
      buf_tag_q    <= '0;
      buf_data_q   <= '0;
      flush_seen_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mcn_q     <= mcn_d;
      req_cnt_q <= req_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      line_q    <= line_d;
`ifdef LINE_FETCH_HIT_EN
      buf_vld_q    <= buf_vld_d;
      buf_tag_q    <= buf_tag_d;
      buf_data_q   <= buf_data_d;
      flush_seen_q <= flush_seen_d;
`endif
    end
  end

endmodule

// File: tb/tb_ptw_line_fetch.sv
// tb/tb_ptw_line_fetch.sv - directed and randomized line fetches against a bus model and line-level reference
module tb_ptw_line_fetch;

  logic         clock;
  logic         reset;
  logic         mem_req_i_valid;
  logic         mem_req_i_ready;
  logic [57:0]  mem_req_i_bits_mcn;
  logic         mem_resp_o_valid;
  logic         mem_resp_o_ready;
  logic [511:0] mem_resp_o_bits_data;
  logic         bus_req_o_valid;
  logic         bus_req_o_ready;
  logic [63:0]  bus_req_o_bits_addr;
  logic         bus_resp_i_valid;
  logic         bus_resp_i_ready;
  logic [63:0]  bus_resp_i_bits_data;
  logic         flush_i;

  ptw_line_fetch #(.MCN_W(58), .ADDR_W(64)) dut (
    .clock                (clock),
    .reset                (reset),
    .mem_req_i_valid      (mem_req_i_valid),
    .mem_req_i_ready      (mem_req_i_ready),
    .mem_req_i_bits_mcn   (mem_req_i_bits_mcn),
    .mem_resp_o_valid     (mem_resp_o_valid),
    .mem_resp_o_ready     (mem_resp_o_ready),
    .mem_resp_o_bits_data (mem_resp_o_bits_data),
    .bus_req_o_valid      (bus_req_o_valid),
    .bus_req_o_ready      (bus_req_o_ready),
    .bus_req_o_bits_addr  (bus_req_o_bits_addr),
    .bus_resp_i_valid     (bus_resp_i_valid),
    .bus_resp_i_ready     (bus_resp_i_ready),
    .bus_resp_i_bits_data (bus_resp_i_bits_data),
    .flush_i              (flush_i)
  );

  typedef struct {
    logic [63:0] addr;
    int          due;
  } beat_t;

  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  beat_t        pend[$];
  logic [63:0]  addr_log[$];
  int           beats_done = 0;
  bit           bp_mode = 0;
  bit           bp_phase = 0;
  int           bus_lat = 1;
  bit           simple_data = 0;
  logic [63:0]  salt;

  bit           m_vld = 0;
  logic [57:0]  m_tag = '0;
  logic [511:0] m_line = '0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  function automatic logic [63:0] beat_data(input logic [63:0] addr);
    if (simple_data) return 64'hA0 + 64'(addr[5:3]);
    return {addr[31:0] ^ salt[63:32], (addr[31:0] * 32'h9E3779B1) ^ salt[31:0]};
  endfunction

  function automatic logic [63:0] beat_addr(input logic [57:0] mcn, input int i);
    return {mcn, 6'b000000} + 64'(8 * i);
  endfunction

  // Bus model: pipelined read with configurable latency and request back-pressure.
  always @(negedge clock) begin
    beat_t b;
    if (reset) begin
      pend.delete();
      bus_req_o_ready = 1'b0;
      bus_resp_i_valid = 1'b0;
      bus_resp_i_bits_data = '0;
    end else begin
      bp_phase = ~bp_phase;
      bus_req_o_ready = bp_mode ? bp_phase : 1'b1;
      if (bus_req_o_valid && bus_req_o_ready) begin
        b.addr = bus_req_o_bits_addr;
        b.due = cyc + bus_lat;
        pend.push_back(b);
        addr_log.push_back(bus_req_o_bits_addr);
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        bus_resp_i_valid = 1'b1;
        bus_resp_i_bits_data = beat_data(pend[0].addr);
        if (bus_resp_i_ready) begin
          void'(pend.pop_front());
          beats_done++;
        end
      end else begin
        bus_resp_i_valid = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_fetch(input logic [57:0] mcn, input int stall, input bit flush_with_req,
                          input int flush_at, input bit chk_lat);
    logic [511:0] exp_line;
    bit exp_hit;
    int t;
    int nexp;
    exp_hit = 0;
`ifdef LINE_FETCH_HIT_EN
    exp_hit = m_vld && (m_tag == mcn) && !flush_with_req;
    if (flush_with_req) m_vld = 0;
`endif
    if (exp_hit) exp_line = m_line;
    else for (int i = 0; i < 8; i++) exp_line[64*i +: 64] = beat_data(beat_addr(mcn, i));
    addr_log.delete();
    @(negedge clock);
    check("req_ready_idle", 512'(mem_req_i_ready), 512'(1));
    mem_req_i_valid = 1'b1;
    mem_req_i_bits_mcn = mcn;
    flush_i = flush_with_req;
    t = 0;
    do begin
      @(negedge clock);
      t++;
      mem_req_i_valid = 1'b0;
      flush_i = (t == flush_at);
      if (t == 1 && chk_lat && !exp_hit) check("first_bus_req_n1", 512'(bus_req_o_valid), 512'(1));
    end while (!mem_resp_o_valid && t < 400);
    flush_i = 1'b0;
    check("resp_seen", 512'(mem_resp_o_valid), 512'(1));
    if (exp_hit) check("hit_latency", 512'(t), 512'(1));
    else if (chk_lat) check("miss_latency", 512'(t), 512'(10));
    check("line_data", mem_resp_o_bits_data, exp_line);
    for (int s = 0; s < stall; s++) begin
      @(negedge clock);
      check("stall_valid", 512'(mem_resp_o_valid), 512'(1));
      check("stall_data", mem_resp_o_bits_data, exp_line);
      check("stall_req_ready", 512'(mem_req_i_ready), 512'(0));
    end
    mem_resp_o_ready = 1'b1;
    @(negedge clock);
    mem_resp_o_ready = 1'b0;
    check("req_ready_after_hs", 512'(mem_req_i_ready), 512'(1));
    check("resp_valid_dropped", 512'(mem_resp_o_valid), 512'(0));
    nexp = exp_hit ? 0 : 8;
    check("bus_beat_count", 512'(addr_log.size()), 512'(nexp));
    for (int i = 0; i < addr_log.size() && i < 8; i++)
      check("beat_addr", 512'(addr_log[i]), 512'(beat_addr(mcn, i)));
    if (!exp_hit) begin
      m_vld = (flush_at <= 0);
      m_tag = mcn;
      m_line = exp_line;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    logic [57:0] mcn;
    bit lat_ok;
    salt = {$urandom, $urandom};
    reset = 1'b1;
    mem_req_i_valid = 1'b0;
    mem_req_i_bits_mcn = '0;
    mem_resp_o_ready = 1'b0;
    flush_i = 1'b0;
    bus_req_o_ready = 1'b0;
    bus_resp_i_valid = 1'b0;
    bus_resp_i_bits_data = '0;
    repeat (3) @(negedge clock);
    check("rst_req_ready", 512'(mem_req_i_ready), 512'(1));
    check("rst_bus_req_valid", 512'(bus_req_o_valid), 512'(0));
    check("rst_resp_valid", 512'(mem_resp_o_valid), 512'(0));
    check("rst_bus_resp_ready", 512'(bus_resp_i_ready), 512'(0));
    check("rst_resp_data", mem_resp_o_bits_data, 512'(0));
    check("rst_bus_addr", 512'(bus_req_o_bits_addr), 512'(0));
    reset = 1'b0;

    simple_data = 1;
    do_fetch(58'h12345, 0, 0, 0, 1);
    simple_data = 0;

    bp_mode = 1; bus_lat = 3;
    do_fetch(58'h2468ACE, 0, 0, 0, 0);
    bp_mode = 0; bus_lat = 1;

    do_fetch(58'h3F00D, 5, 0, 0, 1);

    // Reset after three beats have returned.
    b0 = beats_done;
    @(negedge clock);
    mem_req_i_valid = 1'b1;
    mem_req_i_bits_mcn = 58'h33;
    @(negedge clock);
    mem_req_i_valid = 1'b0;
    for (int k = 0; k < 100 && beats_done < b0 + 3; k++) @(negedge clock);
    check("three_beats_before_reset", 512'(beats_done - b0 >= 3), 512'(1));
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("midrst_req_ready", 512'(mem_req_i_ready), 512'(1));
    check("midrst_bus_req_valid", 512'(bus_req_o_valid), 512'(0));
    check("midrst_resp_valid", 512'(mem_resp_o_valid), 512'(0));
    reset = 1'b0;
    m_vld = 0;
    do_fetch(58'h7, 0, 0, 0, 1);

`ifdef LINE_FETCH_HIT_EN
    do_fetch(58'h40, 0, 0, 0, 1);
    do_fetch(58'h40, 2, 0, 0, 1);
    @(negedge clock);
    flush_i = 1'b1;
    @(negedge clock);
    flush_i = 1'b0;
    m_vld = 0;
    do_fetch(58'h40, 0, 0, 0, 1);
    do_fetch(58'h40, 0, 1, 0, 1);
    do_fetch(58'h80, 0, 0, 3, 1);
    do_fetch(58'h80, 0, 0, 0, 1);
`endif

    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 1) == 1) mcn = 58'h100 + 58'($urandom_range(0, 2));
      else mcn = {26'($urandom), 32'($urandom)};
      bp_mode = 1'($urandom_range(0, 1));
      bus_lat = $urandom_range(1, 4);
      lat_ok = !bp_mode && (bus_lat == 1);
      do_fetch(mcn, $urandom_range(0, 3), 0, 0, lat_ok);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ptw_line_fetch.md
# ptw_line_fetch

Line-fetch adapter between the VLB page-table walker's memory port and the 64-bit system bus. Accepts one cache-line request (a memory cache-line number, MCN) from the walker and issues eight pipelined 64-bit read beats. Assembles the returned beats into a 512-bit line and hands it back on the walker's response channel. Holds at most one line transaction at a time.

## Interface

Parameters:
- MCN_W, 58: width of the cache-line number; byte address = {mcn, 6'b0}.
- ADDR_W, 64: bus byte-address width; must be at least MCN_W+6.

Ports. One clock; reset is synchronous and active-high.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_req_i_valid  in  1  walker line request valid.
- mem_req_i_ready  out  1  block can accept a request.
- mem_req_i_bits_mcn  in  MCN_W  line number requested.
- mem_resp_o_valid  out  1  assembled line valid.
- mem_resp_o_ready  in  1  walker accepts the line.
- mem_resp_o_bits_data  out  512  assembled line; beat i occupies bits [64i+63:64i].
- bus_req_o_valid  out  1  beat read request valid.
- bus_req_o_ready  in  1  bus accepts the beat request.
- bus_req_o_bits_addr  out  ADDR_W  beat byte address = {mcn, 6'b0} + 8*i.
- bus_resp_i_valid  in  1  beat data valid; beats return in request order.
- bus_resp_i_ready  out  1  block accepts beat data.
- bus_resp_i_bits_data  in  64  beat data.
- flush_i  in  1  invalidate line buffer; used only with LINE_FETCH_HIT_EN.

## Operation

States are IDLE, BUSY and RESP.
- **Reset values:** state IDLE, req_cnt=0, rsp_cnt=0. All valid outputs are 0, mem_resp_o_bits_data=0 and bus_req_o_bits_addr=0.
- **IDLE:**
  - mem_req_i_ready=1.
  - On a request handshake: latch the MCN, clear req_cnt/rsp_cnt, go to BUSY.
- **BUSY:**
  - bus_req_o_valid = (req_cnt<8). Address uses req_cnt as the beat index. req_cnt increments on each bus_req handshake.
  - bus_resp_i_ready=1. Each beat handshake writes data into slot rsp_cnt, then rsp_cnt increments.
  - When the 8th beat is accepted (rsp_cnt 7→8), go to RESP.
  - Request and response handshakes in the same cycle are both taken.
- **RESP:**
  - mem_resp_o_valid=1. Data is held stable until the handshake.
  - On the handshake, go to IDLE.
- Counters are 4 bits and saturate at 8. No wrap-around is possible.
- A beat response arriving in IDLE or RESP is not accepted (ready=0).
- Reset mid-operation aborts the transaction, drops any partial line, and returns to IDLE. The bus is reset on the same reset, so no stale beats arrive afterwards.

## Timing

- mem_req_i_ready, bus_req_o_valid, bus_resp_i_ready and mem_resp_o_valid decode directly from state and counters. None is combinationally dependent on any input.
- Request accepted at cycle N: first bus_req_o_valid at N+1.
- Zero-wait bus with 1-cycle read latency: beat requests at N+1..N+8, beats at N+2..N+9, mem_resp_o_valid at N+10.
- RESP handshake at K: mem_req_i_ready=1 at K+1. Back-to-back request period is 11 cycles minimum.
- Bus back-pressure stalls only the affected counter. Beat order and addresses are unchanged.

## Configuration

- **LINE_FETCH_HIT_EN defined:**
  - Adds a one-entry line buffer (valid bit, MCN tag, 512-bit data), written when a fetch completes and reset to invalid.
  - A request in IDLE whose MCN equals the tag while valid=1 goes straight to RESP with the buffered data. mem_resp_o_valid rises at N+1 with no bus traffic.
  - flush_i clears valid in the cycle it is seen. If flush_i is seen at any point during BUSY, the completing line is still returned but is not recorded in the buffer.
  - flush_i coincident with a hit request in IDLE: flush wins, and the request is fetched from the bus.
- **Not defined:** no buffer; every request goes to the bus; flush_i is ignored.

## Test plan

- **Single fetch:** mcn=0x12345, zero-wait bus, beat i data=0xA0+i. Required: addresses 0x48D140..0x48D178 in steps of 8; line word i=0xA0+i; mem_resp_o_valid at N+10.
- **Back-pressure:** bus_req_o_ready low on alternate cycles, bus_resp_i_valid delayed 3 cycles. Required: same 8 addresses in order; correct line; no duplicate or skipped beat.
- **Response stall:** mem_resp_o_ready held low 5 cycles. Required: valid and data stable throughout; mem_req_i_ready=0 until the cycle after the handshake.
- **Reset mid-fetch:** reset after 3 beats returned. Required: next cycle all valids are 0 and mem_req_i_ready=1. A new fetch of mcn=0x7 returns only its own beats.
- **Hit path (LINE_FETCH_HIT_EN):** fetch mcn=0x40, then request 0x40 again. Required: resp at N+1, zero bus requests.
  - Then pulse flush_i and request 0x40: a full 8-beat bus fetch.
- **Flush during fetch (LINE_FETCH_HIT_EN):** flush_i during BUSY for mcn=0x80, then request 0x80 again. Required: the second request issues 8 bus beats.
